if_id_fetch_queue: RTL and testbench
====================================

// Module: if_id_fetch_queue
// PURPOSE
//  Instruction queue between IF/IM and ID, DEPTH entries deep. Each entry holds one fetched instruction word and its PC+4.
//  Absorbs ID stalls without losing in-flight fetches; back-pressures IF when full.
//  Discards all queued fetches when ID redirects the PC (branch/jump taken).
//  Replaces the plain IF/ID latch; ID always sees a valid instruction or a NOP bubble.
// PARAMETERS
//  DEPTH      2             entries; power of two, >= 2
//  DATA_W     32            instruction and address width
//  NOP_INSTR  32'h00000000  bubble word (sll $0,$0,0) driven when empty
// PORTS
//  CLOCK                        in   1       single clock; all state updates on rising edge
//  RESET                        in   1       synchronous, active-low; sampled on CLOCK rising edge only
//  STALL                        in   1       ID cannot accept an instruction this cycle
//  FLUSH                        in   1       ID redirect taken (same cycle as AltPCEnable to IF)
//  FetchValid_IN                in   1       IF presents a new fetch this cycle
//  Instruction_IN               in   DATA_W  instruction word from IM
//  InstructionAddressPlus4_IN   in   DATA_W  PC+4 from IF
//  Instruction_OUT              out  DATA_W  head instruction, or NOP_INSTR when empty
//  InstructionAddressPlus4_OUT  out  DATA_W  head PC+4, or 0 when empty
//  Valid_OUT                    out  1       head entry is a real instruction
//  FetchStall_OUT               out  1       queue full; IF must hold its PC
//  Count_OUT                    out  $clog2(DEPTH)+1  number of occupied entries
// BEHAVIOUR
//  Reset (RESET=0 at a CLOCK edge):
//   - count, read pointer and write pointer go to 0.
//   - Outputs: Valid_OUT=0, Instruction_OUT=NOP_INSTR, InstructionAddressPlus4_OUT=0, FetchStall_OUT=0, Count_OUT=0.
//   - Reset asserted mid-operation drops all entries; no in-flight write completes.
//  Priority at each edge: RESET > FLUSH > push/pop.
//  pop  = Valid_OUT && !STALL.
//  push = FetchValid_IN && (count < DEPTH || pop).
//   - A push while full is legal only when a pop occurs in the same cycle.
//   - Otherwise the fetch is dropped and an assertion fires.
//  Push and pop in the same cycle: count is unchanged, both pointers advance.
//  Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH; there is no separate wrap bit, because count disambiguates full/empty.
//  Latency: a word pushed at edge t is visible on the outputs after edge t (show-ahead).
//   - When empty: push at edge t gives Valid_OUT=1 in cycle t+1.
//   - No combinational path from the *_IN ports to the outputs.
//  Outputs are decoded from registered state only:
//   - Head data is read from storage[rd_ptr], muxed to NOP_INSTR/0 when count==0.
//   - FetchStall_OUT = (count==DEPTH). It does not depend on STALL, so there is no combinational loop through IF.
//  FLUSH=1 at an edge:
//   - count and both pointers go to 0; Valid_OUT=0 next cycle.
//   - A same-cycle push is discarded; FLUSH wins over STALL.
//   - The first post-redirect fetch arrives in the following cycle and is accepted normally.
//  Stored entries hold their value through STALL indefinitely. Storage is not cleared on reset or flush; only validity is.
//  Arithmetic: count increments/decrements by at most 1 per cycle and never exceeds DEPTH or goes below 0.
// STRUCTURE
//  Shared package (pipeline_pkg): NOP_INSTR constant, DATA_W, fetch-entry layout {instr, pc_plus4}.
//  One sub-module: fetch_queue_store.
//   - DEPTH x (2*DATA_W) register array.
//   - Synchronous write port, asynchronous read port.
//  The control logic (pointers, count, flush, outputs) stays in the top module.
// TESTING
//  1. Reset, then push 0x24020005/0xBFC00004 with STALL=0
//     -> Valid_OUT=1 next cycle with those values; Count_OUT=1.
//  2. STALL=1; push 3 fetches (DEPTH=2)
//     -> FetchStall_OUT=1 after 2; third fetch dropped; assertion fires.
//     -> Head remains the first word while stalled.
//  3. Queue full; STALL=0; FetchValid_IN=1 for 4 cycles
//     -> push+pop each cycle; Count_OUT stays 2; outputs follow FIFO order.
//     -> Pointers wrap with no loss.
//  4. Count=2; FLUSH=1 with FetchValid_IN=1 and STALL=1
//     -> next cycle Count_OUT=0, Valid_OUT=0, Instruction_OUT=0x00000000.
//     -> Next fetch (PC+4=0xBFC00040) accepted.
//  5. Queue holding 2 entries; RESET=0 for one cycle mid-stream
//     -> all outputs at reset values after the edge.
//     -> RESET pulsed between edges has no effect (synchronous).
//  6. Empty queue; STALL=1, FetchValid_IN=1
//     -> entry accepted; Valid_OUT=1, held until STALL drops.
//     -> Pop occurs on the first cycle with STALL=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath width, bubble word and fetch-entry layout.
package pipeline_pkg;

   localparam int unsigned DATA_W = 32;
   localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [DATA_W-1:0] pcPlus4;
   } fetchEntry_t;

   localparam int unsigned ENTRY_W = $bits(fetchEntry_t);

endpackage

// File: rtl/fetch_queue_store.sv
// Fetch-queue storage: DEPTH entries, synchronous write, asynchronous read.
module fetch_queue_store #(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned ENTRY_W = 64,
   parameter int unsigned PTR_W   = 1
) (
   input  logic               CLOCK,
   input  logic               WriteEnable,
   input  logic [PTR_W-1:0]   WriteAddress,
   input  logic [ENTRY_W-1:0] WriteData,
   input  logic [PTR_W-1:0]   ReadAddress,
   output logic [ENTRY_W-1:0] ReadData
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   // Contents are never cleared; validity is tracked by the controller.
   always_ff @(posedge CLOCK) begin
      if (WriteEnable) begin
         mem[WriteAddress] <= WriteData;
      end
   end

   assign ReadData = mem[ReadAddress];

endmodule

// File: rtl/if_id_fetch_queue.sv
// Show-ahead instruction queue between IF and ID; stalls IF when full, drops all on redirect.
module if_id_fetch_queue
   import pipeline_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned DATA_W = pipeline_pkg::DATA_W,
   parameter logic [DATA_W-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
   input  logic                      CLOCK,
   input  logic                      RESET,
   input  logic                      STALL,
   input  logic                      FLUSH,
   input  logic                      FetchValid_IN,
   input  logic [DATA_W-1:0]         Instruction_IN,
   input  logic [DATA_W-1:0]         InstructionAddressPlus4_IN,
   output logic [DATA_W-1:0]         Instruction_OUT,
   output logic [DATA_W-1:0]         InstructionAddressPlus4_OUT,
   output logic                      Valid_OUT,
   output logic                      FetchStall_OUT,
   output logic [$clog2(DEPTH):0]    Count_OUT
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
   localparam int unsigned STORE_W = 2 * DATA_W;

   logic [PTR_W-1:0]   rdPtr;
   logic [PTR_W-1:0]   wrPtr;
   logic [CNT_W-1:0]   count;
   logic               isFull;
   logic               pop;
   logic               push;
   logic               writeEnable;
   logic [STORE_W-1:0] writeData;
   logic [STORE_W-1:0] headData;

   assign isFull      = (count == CNT_W'(DEPTH));
   assign pop         = Valid_OUT && !STALL;
   assign push        = FetchValid_IN && (!isFull || pop);
   assign writeEnable = RESET && !FLUSH && push;
   assign writeData   = {Instruction_IN, InstructionAddressPlus4_IN};

   // Pointers wrap naturally since DEPTH is a power of two; count resolves full vs empty.
   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (FLUSH) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + PTR_W'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // A fetch presented while full with no drain is lost.
   always_ff @(posedge CLOCK) begin
      if (RESET && !FLUSH && FetchValid_IN) begin
         assert (push)
            else $warning("fetch queue overflow: fetch dropped while full");
      end
   end

   fetch_queue_store #(
      .DEPTH   (DEPTH),
      .ENTRY_W (STORE_W),
      .PTR_W   (PTR_W)
   ) store (
      .CLOCK        (CLOCK),
      .WriteEnable  (writeEnable),
      .WriteAddress (wrPtr),
      .WriteData    (writeData),
      .ReadAddress  (rdPtr),
      .ReadData     (headData)
   );

   assign Valid_OUT                   = (count != '0);
   assign FetchStall_OUT              = isFull;
   assign Count_OUT                   = count;
   assign Instruction_OUT             = Valid_OUT ? headData[STORE_W-1:DATA_W] : NOP_INSTR;
   assign InstructionAddressPlus4_OUT = Valid_OUT ? headData[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench for if_id_fetch_queue (DEPTH=2) using immediate assertions.
module tb_if_id_fetch_queue;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        STALL;
   logic        FLUSH;
   logic        FetchValid_IN;
   logic [31:0] Instruction_IN;
   logic [31:0] InstructionAddressPlus4_IN;
   logic [31:0] Instruction_OUT;
   logic [31:0] InstructionAddressPlus4_OUT;
   logic        Valid_OUT;
   logic        FetchStall_OUT;
   logic [1:0]  Count_OUT;

   int total = 0;
   int bad   = 0;

   if_id_fetch_queue #(.DEPTH(2)) dut (
      .CLOCK                       (CLOCK),
      .RESET                       (RESET),
      .STALL                       (STALL),
      .FLUSH                       (FLUSH),
      .FetchValid_IN               (FetchValid_IN),
      .Instruction_IN              (Instruction_IN),
      .InstructionAddressPlus4_IN  (InstructionAddressPlus4_IN),
      .Instruction_OUT             (Instruction_OUT),
      .InstructionAddressPlus4_OUT (InstructionAddressPlus4_OUT),
      .Valid_OUT                   (Valid_OUT),
      .FetchStall_OUT              (FetchStall_OUT),
      .Count_OUT                   (Count_OUT)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
         else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   task automatic chkAll(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic fs, input logic [1:0] cnt);
      chk({tag, ".valid"}, 32'(Valid_OUT), 32'(v));
      chk({tag, ".instr"}, Instruction_OUT, ins);
      chk({tag, ".pc4"},   InstructionAddressPlus4_OUT, pc);
      chk({tag, ".stall"}, 32'(FetchStall_OUT), 32'(fs));
      chk({tag, ".count"}, 32'(Count_OUT), 32'(cnt));
   endtask

   task automatic fetch(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      FetchValid_IN              = v;
      Instruction_IN             = ins;
      InstructionAddressPlus4_IN = pc;
   endtask

   initial begin
      RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
      fetch(1'b0, 32'h0, 32'h0);
      step(); step();
      chkAll("reset", 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
      RESET = 1'b1;

      // 1: single push, visible next cycle
      fetch(1'b1, 32'h2402_0005, 32'hBFC0_0004);
      step();
      chkAll("t1.push", 1'b1, 32'h2402_0005, 32'hBFC0_0004, 1'b0, 2'd1);
      fetch(1'b0, 32'h0, 32'h0);
      step();
      chkAll("t1.pop", 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);

      // 2: stalled, three fetches; third is dropped
      STALL = 1'b1;
      fetch(1'b1, 32'hAAAA_0001, 32'hBFC0_0008);
      step();
      chkAll("t2.a", 1'b1, 32'hAAAA_0001, 32'hBFC0_0008, 1'b0, 2'd1);
      fetch(1'b1, 32'hAAAA_0002, 32'hBFC0_000C);
      step();
      chkAll("t2.b", 1'b1, 32'hAAAA_0001, 32'hBFC0_0008, 1'b1, 2'd2);
      fetch(1'b1, 32'hAAAA_0003, 32'hBFC0_0010);
      step();
      chkAll("t2.drop", 1'b1, 32'hAAAA_0001, 32'hBFC0_0008, 1'b1, 2'd2);

      // 3: full with push+pop every cycle, pointers wrap
      STALL = 1'b0;
      fetch(1'b1, 32'hBBBB_0004, 32'hBFC0_0014);
      step();
      chkAll("t3.c1", 1'b1, 32'hAAAA_0002, 32'hBFC0_000C, 1'b1, 2'd2);
      fetch(1'b1, 32'hBBBB_0005, 32'hBFC0_0018);
      step();
      chkAll("t3.c2", 1'b1, 32'hBBBB_0004, 32'hBFC0_0014, 1'b1, 2'd2);
      fetch(1'b1, 32'hBBBB_0006, 32'hBFC0_001C);
      step();
      chkAll("t3.c3", 1'b1, 32'hBBBB_0005, 32'hBFC0_0018, 1'b1, 2'd2);
      fetch(1'b1, 32'hBBBB_0007, 32'hBFC0_0020);
      step();
      chkAll("t3.c4", 1'b1, 32'hBBBB_0006, 32'hBFC0_001C, 1'b1, 2'd2);

      // 4: flush beats stall and same-cycle push
      FLUSH = 1'b1; STALL = 1'b1;
      fetch(1'b1, 32'hCCCC_0008, 32'hBFC0_0024);
      step();
      chkAll("t4.flush", 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
      FLUSH = 1'b0;
      fetch(1'b1, 32'hDDDD_0009, 32'hBFC0_0040);
      step();
      chkAll("t4.redir", 1'b1, 32'hDDDD_0009, 32'hBFC0_0040, 1'b0, 2'd1);
      fetch(1'b1, 32'hDDDD_000A, 32'hBFC0_0044);
      step();
      chkAll("t4.fill", 1'b1, 32'hDDDD_0009, 32'hBFC0_0040, 1'b1, 2'd2);

      // 5: reset pulse between edges is ignored; reset at an edge clears
      fetch(1'b0, 32'h0, 32'h0);
      RESET = 1'b0;
      #3;
      RESET = 1'b1;
      step();
      chkAll("t5.glitch", 1'b1, 32'hDDDD_0009, 32'hBFC0_0040, 1'b1, 2'd2);
      RESET = 1'b0;
      fetch(1'b1, 32'hEEEE_000B, 32'hBFC0_0048);
      step();
      chkAll("t5.reset", 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
      RESET = 1'b1;

      // 6: push while stalled into empty queue, held, popped when stall drops
      STALL = 1'b1;
      fetch(1'b1, 32'hFFFF_000C, 32'hBFC0_004C);
      step();
      chkAll("t6.push", 1'b1, 32'hFFFF_000C, 32'hBFC0_004C, 1'b0, 2'd1);
      fetch(1'b0, 32'h0, 32'h0);
      step(); step();
      chkAll("t6.hold", 1'b1, 32'hFFFF_000C, 32'hBFC0_004C, 1'b0, 2'd1);
      STALL = 1'b0;
      step();
      chkAll("t6.pop", 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
